// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty, edge/centre
// alignment, and shadowed parameters that take effect only at period boundaries.
module pwm_multichannel #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      update_parameters,
  input  logic [WIDTH-1:0]          pwm_period,
  input  logic [CHANNELS*WIDTH-1:0] pwm_duty_cycle,
  input  logic                      center_aligned,
  input  logic [CHANNELS-1:0]       channel_enable,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_start,
  output logic                      update_pending
);

  localparam logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(256);
  localparam logic [WIDTH-1:0] ONE            = WIDTH'(1);

  logic [WIDTH-1:0] r_act_period, r_sh_period;
  logic             r_act_center, r_sh_center;
  logic [WIDTH-1:0] r_act_duty [CHANNELS];
  logic [WIDTH-1:0] r_sh_duty  [CHANNELS];
  logic             r_pending;
  logic [WIDTH-1:0] r_cnt;
  logic             r_down;
  logic [CHANNELS-1:0] r_pwm;
  logic             r_period_start;

  logic [WIDTH-1:0] w_in_period, w_eff_period, w_cur_period;
  logic             w_eff_center, w_cur_center;
  logic [WIDTH-1:0] w_in_duty  [CHANNELS];
  logic [WIDTH-1:0] w_eff_duty [CHANNELS];
  logic [WIDTH-1:0] w_cur_duty [CHANNELS];
  logic             w_start;
  logic [WIDTH-1:0] w_cnt_next;
  logic             w_down_next;
  logic [CHANNELS-1:0] w_pwm_next;

  // r_cnt holds the phase about to be shown on the outputs, so a boundary is detected
  // one cycle early and the new parameters already govern the k=0 output.
  assign w_start      = (r_cnt == '0) && !r_down;
  assign w_in_period  = (pwm_period == '0) ? ONE : pwm_period;
  // Shadow equals active whenever nothing is pending, so it is always the value to apply.
  assign w_eff_period = update_parameters ? w_in_period : r_sh_period;
  assign w_eff_center = update_parameters ? center_aligned : r_sh_center;
  assign w_cur_period = w_start ? w_eff_period : r_act_period;
  assign w_cur_center = w_start ? w_eff_center : r_act_center;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [WIDTH-1:0] w_duty_raw;
    assign w_duty_raw     = pwm_duty_cycle[gi*WIDTH +: WIDTH];
    assign w_in_duty[gi]  = (w_duty_raw > pwm_period) ? pwm_period : w_duty_raw;
    assign w_eff_duty[gi] = update_parameters ? w_in_duty[gi] : r_sh_duty[gi];
    assign w_cur_duty[gi] = w_start ? w_eff_duty[gi] : r_act_duty[gi];
    assign w_pwm_next[gi] = channel_enable[gi] &&
                            (w_cur_center ? (r_cnt >= (w_cur_period - w_cur_duty[gi]))
                                          : (r_cnt < w_cur_duty[gi]));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_act_duty[gi] <= '0;
        r_sh_duty[gi]  <= '0;
      end else begin
        if (update_parameters) r_sh_duty[gi] <= w_in_duty[gi];
        if (w_start)           r_act_duty[gi] <= w_eff_duty[gi];
      end
    end
  end

  // Centre mode walks up to P-1, holds it once more on the way down, then back to 0.
  always_comb begin
    w_cnt_next  = r_cnt;
    w_down_next = r_down;
    if (!w_cur_center) begin
      w_down_next = 1'b0;
      w_cnt_next  = (r_cnt == w_cur_period - ONE) ? '0 : r_cnt + ONE;
    end else if (!r_down) begin
      if (r_cnt == w_cur_period - ONE) w_down_next = 1'b1;
      else                             w_cnt_next  = r_cnt + ONE;
    end else begin
      if (r_cnt == '0) w_down_next = 1'b0;
      else             w_cnt_next  = r_cnt - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_act_period   <= DEFAULT_PERIOD;
      r_sh_period    <= DEFAULT_PERIOD;
      r_act_center   <= 1'b0;
      r_sh_center    <= 1'b0;
      r_pending      <= 1'b0;
      r_cnt          <= '0;
      r_down         <= 1'b0;
      r_pwm          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_down         <= w_down_next;
      r_pwm          <= w_pwm_next;
      r_period_start <= w_start;
      if (update_parameters) begin
        r_sh_period <= w_in_period;
        r_sh_center <= center_aligned;
      end
      if (w_start) begin
        r_act_period <= w_eff_period;
        r_act_center <= w_eff_center;
        r_pending    <= 1'b0;
      end else if (update_parameters) begin
        r_pending    <= 1'b1;
      end
    end
  end

  assign pwm            = r_pwm;
  assign period_start   = r_period_start;
  assign update_pending = r_pending;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: directed scenarios plus random traffic, every cycle compared
// against a period/phase reference model.
module tb_pwm_multichannel;
  localparam int W  = 16;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              update_parameters;
  logic [W-1:0]      pwm_period;
  logic [CH*W-1:0]   pwm_duty_cycle;
  logic              center_aligned;
  logic [CH-1:0]     channel_enable;
  logic [CH-1:0]     pwm;
  logic              period_start;
  logic              update_pending;

  always #5 clk = ~clk;

  pwm_multichannel #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk               (clk),
    .reset             (reset),
    .update_parameters (update_parameters),
    .pwm_period        (pwm_period),
    .pwm_duty_cycle    (pwm_duty_cycle),
    .center_aligned    (center_aligned),
    .channel_enable    (channel_enable),
    .pwm               (pwm),
    .period_start      (period_start),
    .update_pending    (update_pending)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus values presented on the inputs
  int      s_p;
  int      s_d [CH];
  bit      s_mode;
  bit [CH-1:0] s_en;

  // reference model: active and shadow parameters, phase k of the displayed cycle
  int      m_p, sh_p;
  int      m_d [CH];
  int      sh_d [CH];
  bit      m_mode, sh_mode, m_pend;
  int      m_k;
  bit [CH-1:0] exp_pwm;
  bit      exp_ps, exp_pend;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int period_len();
    return m_mode ? 2 * m_p : m_p;
  endfunction

  // Edge: high for the first D cycles. Centre: 2D cycles centred on the midpoint of 2P.
  function automatic bit level(int k, int p, int d, bit mode);
    if (mode) return (k >= p - d) && (k <= p + d - 1);
    return k < d;
  endfunction

  task automatic model_step(input bit rst, input bit strb);
    int cp;
    int cd [CH];
    cp = (s_p == 0) ? 1 : s_p;
    for (int i = 0; i < CH; i++) cd[i] = (s_d[i] > s_p) ? s_p : s_d[i];
    if (rst) begin
      m_p = 256; sh_p = 256; m_mode = 0; sh_mode = 0; m_pend = 0; m_k = -1;
      for (int i = 0; i < CH; i++) begin m_d[i] = 0; sh_d[i] = 0; end
      exp_pwm = '0; exp_ps = 0; exp_pend = 0;
      return;
    end
    if (m_k < 0 || m_k == period_len() - 1) begin
      m_k = 0;
      if (strb) begin
        m_p = cp; sh_p = cp; m_mode = s_mode; sh_mode = s_mode;
        for (int i = 0; i < CH; i++) begin m_d[i] = cd[i]; sh_d[i] = cd[i]; end
      end else if (m_pend) begin
        m_p = sh_p; m_mode = sh_mode;
        for (int i = 0; i < CH; i++) m_d[i] = sh_d[i];
      end
      m_pend = 0;
    end else begin
      m_k++;
      if (strb) begin
        sh_p = cp; sh_mode = s_mode; m_pend = 1;
        for (int i = 0; i < CH; i++) sh_d[i] = cd[i];
      end
    end
    exp_ps   = (m_k == 0);
    exp_pend = m_pend;
    for (int i = 0; i < CH; i++) exp_pwm[i] = s_en[i] && level(m_k, m_p, m_d[i], m_mode);
  endtask

  task automatic drive(input bit rst, input bit strb);
    reset             = rst;
    update_parameters = strb;
    pwm_period        = W'(s_p);
    for (int i = 0; i < CH; i++) pwm_duty_cycle[i*W +: W] = W'(s_d[i]);
    center_aligned    = s_mode;
    channel_enable    = s_en;
  endtask

  // One clock: check the cycle being displayed, present inputs, advance the model.
  task automatic tick(input bit rst, input bit strb);
    @(negedge clk);
    check_val("pwm", 32'(pwm), 32'(exp_pwm));
    check_val("period_start", 32'(period_start), 32'(exp_ps));
    check_val("update_pending", 32'(update_pending), 32'(exp_pend));
    drive(rst, strb);
    model_step(rst, strb);
    @(posedge clk);
  endtask

  task automatic wait_last_cycle();
    for (int n = 0; n < 1000 && m_k != period_len() - 1; n++) tick(0, 0);
  endtask

  initial begin
    s_p = 256; s_mode = 0; s_en = '1;
    for (int i = 0; i < CH; i++) s_d[i] = 0;
    drive(1, 0);
    model_step(1, 0);
    repeat (2) @(posedge clk);
    tick(1, 0);

    // idle after reset: default 256-cycle period, all low
    repeat (600) tick(0, 0);

    // edge mode P=10, D={0,3,7,10}
    s_p = 10; s_d[0] = 0; s_d[1] = 3; s_d[2] = 7; s_d[3] = 10;
    tick(0, 1);
    repeat (40) tick(0, 0);

    // mid-period shrink to P=6
    for (int n = 0; n < 20 && m_k != 3; n++) tick(0, 0);
    s_p = 6;
    tick(0, 1);
    repeat (30) tick(0, 0);

    // centre mode P=8, D=3, with a channel gated for a while
    s_p = 8; s_mode = 1;
    for (int i = 0; i < CH; i++) s_d[i] = 3;
    tick(0, 1);
    repeat (30) tick(0, 0);
    s_en = 4'b1011;
    repeat (7) tick(0, 0);
    s_en = '1;
    repeat (25) tick(0, 0);

    // strobe on the last cycle with duty above period, then P=0
    s_mode = 0; s_p = 12;
    for (int i = 0; i < CH; i++) s_d[i] = 20;
    wait_last_cycle();
    tick(0, 1);
    repeat (30) tick(0, 0);
    s_p = 0; s_d[0] = 0; s_d[1] = 1; s_d[2] = 0; s_d[3] = 5;
    tick(0, 1);
    repeat (10) tick(0, 0);

    // reset mid-period with an update pending
    s_p = 40;
    for (int i = 0; i < CH; i++) s_d[i] = 10;
    tick(0, 1);
    repeat (50) tick(0, 0);
    s_p = 30;
    tick(0, 1);
    repeat (5) tick(0, 0);
    tick(1, 0);
    repeat (300) tick(0, 0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      bit rst, strb;
      rst  = ($urandom_range(0, 599) == 0);
      strb = !rst && (m_k >= 0) && ($urandom_range(0, 15) == 0);
      if (strb) begin
        s_p    = $urandom_range(0, 20);
        s_mode = $urandom_range(0, 1);
        for (int i = 0; i < CH; i++) s_d[i] = $urandom_range(0, 24);
      end
      if ($urandom_range(0, 9) == 0) s_en = CH'($urandom);
      tick(rst, strb);
    end
    tick(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
